// File: rtl/alu_pkg.sv
// Shared types and constants for the execute-stage ALU and its FP sub-unit.
package alu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned RES_W  = 64;
  localparam int unsigned MODE_W = 4;

  typedef enum logic [MODE_W-1:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_NOR   = 4'd5,
    ALU_SLL   = 4'd6,
    ALU_SRL   = 4'd7,
    ALU_SRA   = 4'd8,
    ALU_MULU  = 4'd9,
    ALU_MULS  = 4'd10,
    ALU_DIVU  = 4'd11,
    ALU_ADD64 = 4'd12,
    ALU_FADD  = 4'd13,
    ALU_FSUB  = 4'd14,
    ALU_FMUL  = 4'd15
  } alu_mode_e;

  typedef enum logic [1:0] {
    FP_ADD = 2'd0,
    FP_SUB = 2'd1,
    FP_MUL = 2'd2
  } fp_op_e;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  INF_EXP = 8'hFF;
  localparam int          BIAS    = 127;

  typedef struct packed {
    logic [RES_W-1:0] out;
    logic             cf;
    logic             sf;
  } alu_res_t;

  // Modes whose result occupies all 64 bits (sign taken from bit 63).
  function automatic logic is_wide(alu_mode_e m);
    return m inside {ALU_MULU, ALU_MULS, ALU_DIVU, ALU_ADD64};
  endfunction

  // Packs {exc, fp32} from a signed exponent, flushing underflow to +0 and saturating to infinity.
  function automatic logic [32:0] fp_pack(logic s, logic signed [9:0] e, logic [22:0] m);
    if (e <= 10'sd0)
      return '0;
    else if (e >= 10'sd255)
      return {1'b1, s, INF_EXP, 23'd0};
    else
      return {1'b0, s, e[7:0], m};
  endfunction

endpackage

// File: rtl/fp32_addmul.sv
// Combinational single-precision add/sub/mul: flush-to-zero, truncating, NaN on any exp-255 input.
module fp32_addmul
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  fp_op_e      op,
  output logic [31:0] result,
  output logic        exc
);

  logic              sa, sb;
  logic [7:0]        ea, eb;
  logic [23:0]       ma, mb;
  logic              a_big, s_big;
  logic [7:0]        e_big, e_small, e_diff;
  logic [23:0]       m_big, m_small, m_al;
  logic [24:0]       sum;
  logic [4:0]        lead, sh;
  logic signed [9:0] add_e, mul_e;
  logic [22:0]       add_m, mul_m;
  logic [24:0]       prod_hi;

  always_comb begin
    result = '0;
    exc    = 1'b0;

    // Unpack; exponent-0 operands become exact zeros.
    sa = a[31];
    sb = b[31] ^ (op == FP_SUB);
    ea = a[30:23];
    eb = b[30:23];
    ma = (ea == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
    mb = (eb == 8'd0) ? 24'd0 : {1'b1, b[22:0]};

    // Add/sub: align smaller magnitude, combine, renormalise.
    a_big   = {ea, ma} >= {eb, mb};
    s_big   = a_big ? sa : sb;
    e_big   = a_big ? ea : eb;
    e_small = a_big ? eb : ea;
    m_big   = a_big ? ma : mb;
    m_small = a_big ? mb : ma;
    e_diff  = e_big - e_small;
    m_al    = (e_diff >= 8'd25) ? 24'd0 : (m_small >> e_diff);
    sum     = (sa == sb) ? ({1'b0, m_big} + {1'b0, m_al})
                         : ({1'b0, m_big} - {1'b0, m_al});

    lead = 5'd0;
    for (int i = 0; i < 24; i++)
      if (sum[i]) lead = 5'(i);
    sh = 5'd23 - lead;

    if (sum[24]) begin
      add_m = sum[23:1];
      add_e = $signed({2'b00, e_big}) + 10'sd1;
    end else begin
      add_m = sum[22:0] << sh;
      add_e = $signed({2'b00, e_big}) - $signed({5'b00000, sh});
    end

    // Multiply: keep the top 25 bits of the 48-bit mantissa product.
    prod_hi = 25'((48'(ma) * 48'(mb)) >> 23);
    mul_m   = prod_hi[24] ? prod_hi[23:1] : prod_hi[22:0];
    mul_e   = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127
              + (prod_hi[24] ? 10'sd1 : 10'sd0);

    if (ea == INF_EXP || eb == INF_EXP) begin
      result = QNAN;
      exc    = 1'b1;
    end else if (op == FP_MUL) begin
      if (ma != 24'd0 && mb != 24'd0)
        {exc, result} = fp_pack(sa ^ b[31], mul_e, mul_m);
    end else begin
      if (sum != 25'd0)
        {exc, result} = fp_pack(s_big, add_e, add_m);
    end
  end

endmodule

// File: rtl/alu_unit.sv
// One-cycle execute stage: integer/FP result mux with carry and sign flags, registered.
module alu_unit
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [DATA_W-1:0] AHigh,
  input  logic [MODE_W-1:0] mode,
  output logic [RES_W-1:0]  ALU_out,
  output logic              cf,
  output logic              sf
);

  alu_mode_e   mode_e;
  fp_op_e      fp_op;
  logic [31:0] fp_res;
  logic        fp_exc;
  logic [32:0] add33, sub33;
  logic [64:0] add65;
  logic [63:0] mulu, muls;
  alu_res_t    res_c;

  assign mode_e = alu_mode_e'(mode);
  assign fp_op  = (mode_e == ALU_FMUL) ? FP_MUL :
                  (mode_e == ALU_FSUB) ? FP_SUB : FP_ADD;

  fp32_addmul u_fp (
    .a      (A),
    .b      (B),
    .op     (fp_op),
    .result (fp_res),
    .exc    (fp_exc)
  );

  assign add33 = {1'b0, A} + {1'b0, B};
  assign sub33 = {1'b0, A} - {1'b0, B};
  assign add65 = {1'b0, AHigh, A} + {33'd0, B};
  assign mulu  = 64'(A) * 64'(B);
  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign muls  = 64'({{32{A[31]}}, A} * {{32{B[31]}}, B});

  always_comb begin
    res_c = '0;
    case (mode_e)
      ALU_ADD:   begin res_c.out = {32'd0, add33[31:0]}; res_c.cf = add33[32]; end
      ALU_SUB:   begin res_c.out = {32'd0, sub33[31:0]}; res_c.cf = sub33[32]; end
      ALU_AND:   res_c.out = {32'd0, A & B};
      ALU_OR:    res_c.out = {32'd0, A | B};
      ALU_XOR:   res_c.out = {32'd0, A ^ B};
      ALU_NOR:   res_c.out = {32'd0, ~(A | B)};
      ALU_SLL:   res_c.out = {32'd0, A << B[4:0]};
      ALU_SRL:   res_c.out = {32'd0, A >> B[4:0]};
      ALU_SRA:   res_c.out = {32'd0, 32'($signed(A) >>> B[4:0])};
      ALU_MULU:  begin res_c.out = mulu; res_c.cf = (mulu[63:32] != 32'd0); end
      ALU_MULS:  begin res_c.out = muls; res_c.cf = (muls[63:32] != {32{muls[31]}}); end
      ALU_DIVU: begin
        if (B == 32'd0) begin
          res_c.out = {A, 32'hFFFF_FFFF};
          res_c.cf  = 1'b1;
        end else begin
          res_c.out = {A % B, A / B};
        end
      end
      ALU_ADD64: begin res_c.out = add65[63:0]; res_c.cf = add65[64]; end
      ALU_FADD, ALU_FSUB, ALU_FMUL: begin
        res_c.out = {32'd0, fp_res};
        res_c.cf  = fp_exc;
      end
      default: res_c = '0;
    endcase
    res_c.sf = is_wide(mode_e) ? res_c.out[63] : res_c.out[31];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ALU_out <= '0;
      cf      <= 1'b0;
      sf      <= 1'b0;
    end else begin
      ALU_out <= res_c.out;
      cf      <= res_c.cf;
      sf      <= res_c.sf;
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: arithmetic reference model plus pinned directed vectors.
module tb_alu_unit;

  logic        clk;
  logic        rst;
  logic [31:0] a_in, b_in, ah_in;
  logic [3:0]  mode;
  logic [63:0] alu_out;
  logic        cf, sf;

  alu_unit dut (
    .clk     (clk),
    .rst     (rst),
    .A       (a_in),
    .B       (b_in),
    .AHigh   (ah_in),
    .mode    (mode),
    .ALU_out (alu_out),
    .cf      (cf),
    .sf      (sf)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  int n_pass = 0;
  int n_total = 0;

  // Reference FP: op 0 add, 1 sub, 2 mul. Returns {exc, result}.
  function automatic logic [32:0] fp_model(int op, logic [31:0] a, logic [31:0] b);
    int ea, eb, e, eg, es;
    longint ma, mb, mg, ms, mag;
    bit sa, sb, sg, ss;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 255 || eb == 255) return {1'b1, 32'h7FC00000};
    sa = a[31];
    sb = b[31] ^ (op == 1);
    ma = (ea == 0) ? 0 : 8388608 + longint'(a[22:0]);
    mb = (eb == 0) ? 0 : 8388608 + longint'(b[22:0]);
    if (op == 2) begin
      if (ma == 0 || mb == 0) return 33'd0;
      mag = (ma * mb) >> 23;
      e   = ea + eb - 127;
      sg  = a[31] ^ b[31];
    end else begin
      if (ea > eb || (ea == eb && ma >= mb)) begin
        eg = ea; mg = ma; sg = sa; es = eb; ms = mb; ss = sb;
      end else begin
        eg = eb; mg = mb; sg = sb; es = ea; ms = ma; ss = sa;
      end
      ms  = (eg - es >= 25) ? 0 : (ms >> (eg - es));
      mag = (sg == ss) ? mg + ms : mg - ms;
      if (mag == 0) return 33'd0;
      e = eg;
    end
    while (mag >= 16777216) begin mag = mag >> 1; e++; end
    while (mag < 8388608)   begin mag = mag << 1; e--; end
    if (e <= 0)   return 33'd0;
    if (e >= 255) return {1'b1, sg, 8'hFF, 23'd0};
    return {1'b0, sg, 8'(e), 23'(mag)};
  endfunction

  // Reference ALU. Returns {out, cf, sf}.
  function automatic logic [65:0] model(logic [3:0] m, logic [31:0] a, logic [31:0] b, logic [31:0] ah);
    logic [63:0] o;
    logic [64:0] w;
    logic [32:0] f;
    longint sp;
    logic c;
    o = 64'd0;
    c = 1'b0;
    case (m)
      4'd0:  begin w = 65'(a) + 65'(b); o = {32'd0, w[31:0]}; c = w[32]; end
      4'd1:  begin o = {32'd0, 32'(a - b)}; c = (a < b); end
      4'd2:  o = {32'd0, a & b};
      4'd3:  o = {32'd0, a | b};
      4'd4:  o = {32'd0, a ^ b};
      4'd5:  o = {32'd0, ~(a | b)};
      4'd6:  o = {32'd0, 32'(a << b[4:0])};
      4'd7:  o = {32'd0, a >> b[4:0]};
      4'd8:  o = {32'd0, 32'($signed(a) >>> b[4:0])};
      4'd9:  begin o = 64'(a) * 64'(b); c = (o[63:32] != 32'd0); end
      4'd10: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        o  = 64'(sp);
        c  = (sp > 64'sd2147483647) || (sp < -64'sd2147483648);
      end
      4'd11: begin
        if (b == 0) begin o = {a, 32'hFFFFFFFF}; c = 1'b1; end
        else o = {a % b, a / b};
      end
      4'd12: begin w = 65'({ah, a}) + 65'(b); o = w[63:0]; c = w[64]; end
      default: begin
        f = fp_model(int'(m) - 13, a, b);
        o = {32'd0, f[31:0]};
        c = f[32];
      end
    endcase
    return {o, c, (m >= 4'd9 && m <= 4'd12) ? o[63] : o[31]};
  endfunction

  // Directed-vector annotations, owned by the stimulus process.
  logic        lit_en = 1'b0;
  logic [65:0] lit_exp = '0;
  string       lit_name = "";

  logic [65:0] pend_exp, pend_lit_exp;
  logic        pend_lit = 1'b0;
  logic [3:0]  pend_mode;
  string       pend_name;
  logic        model_valid;

  always @(posedge clk) begin
    pend_exp     <= model(mode, a_in, b_in, ah_in);
    pend_mode    <= mode;
    pend_lit     <= lit_en;
    pend_lit_exp <= lit_exp;
    pend_name    <= lit_name;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) model_valid <= 1'b0;
    else     model_valid <= 1'b1;
  end

  task automatic check(input string name, input logic [65:0] got, input logic [65:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got out=%h cf=%b sf=%b, expected out=%h cf=%b sf=%b",
                  name, got[65:2], got[1], got[0], exp[65:2], exp[1], exp[0]);
  endtask

  // Single compare process: outputs sampled on the falling edge.
  always @(negedge clk) begin
    if (rst === 1'b1 || model_valid !== 1'b1) begin
      check("reset_zero", {alu_out, cf, sf}, 66'd0);
    end else begin
      check($sformatf("model_mode%0d", pend_mode), {alu_out, cf, sf}, pend_exp);
      if (pend_lit) check(pend_name, {alu_out, cf, sf}, pend_lit_exp);
    end
  end

  task automatic apply(input logic [3:0] m, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ah, input logic lit, input logic [63:0] eo,
                       input logic ec, input logic es, input string name);
    @(negedge clk);
    mode     = m;
    a_in     = a;
    b_in     = b;
    ah_in    = ah;
    lit_en   = lit;
    lit_exp  = {eo, ec, es};
    lit_name = name;
  endtask

  initial begin
    rst   = 1'b0;
    mode  = 4'd13;
    a_in  = 32'h3FCCCCCC;
    b_in  = 32'h3F999999;
    ah_in = 32'd0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    apply(4'd0,  32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 64'd0, 1'b1, 1'b0, "add_wrap");
    apply(4'd1,  32'd1, 32'd2, 32'd0, 1'b1, 64'h00000000FFFFFFFF, 1'b1, 1'b1, "sub_borrow");
    apply(4'd10, 32'hFFFFFFFF, 32'd2, 32'd0, 1'b1, 64'hFFFFFFFFFFFFFFFE, 1'b0, 1'b1, "muls_neg");
    apply(4'd9,  32'hFFFFFFFF, 32'd2, 32'd0, 1'b1, 64'h00000001FFFFFFFE, 1'b1, 1'b0, "mulu_hi");
    apply(4'd11, 32'd7, 32'd0, 32'd0, 1'b1, 64'h00000007FFFFFFFF, 1'b1, 1'b0, "divu_by0");
    apply(4'd11, 32'd7, 32'd2, 32'd0, 1'b1, 64'h0000000100000003, 1'b0, 1'b0, "divu");
    apply(4'd12, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 1'b1, 64'd0, 1'b1, 1'b0, "add64_carry");
    apply(4'd8,  32'h80000000, 32'h24, 32'd0, 1'b1, 64'h00000000F8000000, 1'b0, 1'b1, "sra_b_high_ignored");
    apply(4'd5,  32'd0, 32'd0, 32'd0, 1'b1, 64'h00000000FFFFFFFF, 1'b0, 1'b1, "nor_zero");
    apply(4'd6,  32'd1, 32'h21, 32'd0, 1'b1, 64'd2, 1'b0, 1'b0, "sll_mask");
    apply(4'd14, 32'h3FCCCCCC, 32'h3F999999, 32'd0, 1'b1, 64'h3ECCCCCC, 1'b0, 1'b0, "fsub");
    apply(4'd14, 32'h3F999999, 32'h3FCCCCCC, 32'd0, 1'b1, 64'hBECCCCCC, 1'b0, 1'b1, "fsub_neg");
    apply(4'd14, 32'h3FCCCCCC, 32'h3FCCCCCC, 32'd0, 1'b1, 64'd0, 1'b0, 1'b0, "fsub_cancel");
    apply(4'd15, 32'h40000000, 32'h40400000, 32'd0, 1'b1, 64'h40C00000, 1'b0, 1'b0, "fmul_2x3");
    apply(4'd15, 32'h7F800000, 32'h3F800000, 32'd0, 1'b1, 64'h7FC00000, 1'b1, 1'b0, "fmul_inf_in");
    apply(4'd15, 32'h00800000, 32'h00800000, 32'd0, 1'b1, 64'd0, 1'b0, 1'b0, "fmul_underflow");
    apply(4'd13, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'd0, 1'b1, 64'h7F800000, 1'b1, 1'b0, "fadd_overflow");
    apply(4'd13, 32'h00000001, 32'h3F800000, 32'd0, 1'b1, 64'h3F800000, 1'b0, 1'b0, "fadd_denorm_flush");
    apply(4'd13, 32'h4B800000, 32'h3F800000, 32'd0, 1'b1, 64'h4B800000, 1'b0, 1'b0, "fadd_far_align");
    apply(4'd13, 32'h3FCCCCCC, 32'h3F999999, 32'd0, 1'b1, 64'h40333332, 1'b0, 1'b0, "fadd");

    // Inputs changed mid-cycle: only the value present at the edge is captured.
    @(negedge clk);
    mode = 4'd0; a_in = 32'd5; b_in = 32'd3;
    lit_en = 1'b1; lit_exp = {64'd6, 1'b0, 1'b0}; lit_name = "mid_cycle_change";
    #2 mode = 4'd4;

    // Asynchronous reset mid-cycle with an FP mode active.
    @(negedge clk);
    lit_en = 1'b0;
    mode = 4'd13; a_in = 32'h3FCCCCCC; b_in = 32'h3F999999;
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;

    for (int m = 0; m < 16; m++)
      for (int k = 0; k < 6; k++)
        apply(4'(m), $urandom, (k == 0) ? 32'd0 : $urandom, $urandom, 1'b0, 64'd0, 1'b0, 1'b0, "");

    @(negedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
